// File: rtl/ibex_fetch_realign_fifo_if.sv
// Fetch-side and decode-side handshakes of the realigning prefetch buffer, plus the flush request.
interface ibex_fetch_realign_fifo_if #(
    parameter int ADDR_W = 32
);
    logic              clear;
    logic [ADDR_W-1:0] clear_addr;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_rdata;
    logic              in_err;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_rdata;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;

    modport slave (
        input  clear, clear_addr, in_valid, in_rdata, in_err, out_ready,
        output in_ready, out_valid, out_rdata, out_addr, out_err
    );

    modport master (
        output clear, clear_addr, in_valid, in_rdata, in_err, out_ready,
        input  in_ready, out_valid, out_rdata, out_addr, out_err
    );
endinterface

// File: rtl/ibex_fetch_realign_fifo.sv
// Word FIFO presenting 16/32-bit instructions realigned to bit 0; a pushed word is visible one cycle later.
// in_ready depends on occupancy only (no pass-through at full); outputs hold while stalled.
module ibex_fetch_realign_fifo #(
    parameter int DEPTH  = 3,
    parameter int ADDR_W = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    ibex_fetch_realign_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]       mem [DEPTH];
    logic [DEPTH-1:0]  err_q;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr, nxt_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] pc, pc_next;

    logic        has1, has2, hw_off, compressed;
    logic [31:0] cur, nxt;
    logic        cur_err, nxt_err;
    logic [15:0] hw;
    logic        push, pop, retire;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        nxt_ptr    = ptr_inc(rd_ptr);
        has1       = (count != '0);
        has2       = (count >= CNT_W'(2));
        hw_off     = pc[1];
        cur        = mem[rd_ptr];
        cur_err    = has1 & err_q[rd_ptr];
        nxt        = has2 ? mem[nxt_ptr] : 32'h0;
        nxt_err    = has2 & err_q[nxt_ptr];
        hw         = hw_off ? cur[31:16] : cur[15:0];
        compressed = (hw[1:0] != 2'b11);

        // An errored head word is presented at once so the fault is never stuck waiting on a refill.
        bus.out_valid = has1 & (compressed | !hw_off | has2 | cur_err);
        bus.out_rdata = hw_off ? {nxt[15:0], cur[31:16]} : cur;
        bus.out_addr  = pc;
        bus.out_err   = cur_err | (hw_off & !compressed & has2 & nxt_err);
        bus.in_ready  = (count < CNT_W'(DEPTH));

        push    = bus.in_valid & bus.in_ready & !bus.clear;
        pop     = bus.out_valid & bus.out_ready & !bus.clear;
        // The head word is done once the instruction reaches its upper half.
        retire  = pop & (hw_off | !compressed);
        pc_next = pc + (compressed ? ADDR_W'(2) : ADDR_W'(4));
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_rdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            pc     <= '0;
            err_q  <= '0;
        end else if (bus.clear) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            pc     <= bus.clear_addr;
        end else begin
            if (push) begin
                err_q[wr_ptr] <= bus.in_err;
                wr_ptr        <= ptr_inc(wr_ptr);
            end
            if (retire) begin
                rd_ptr <= nxt_ptr;
            end
            if (pop) begin
                pc <= pc_next;
            end
            count <= count + CNT_W'(push) - CNT_W'(retire);
        end
    end
endmodule
